counter_mod_n: RTL and testbench
================================

COUNTER_MOD_N -- requirements
Module: counter_mod_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the count value.
REQ-002 SHALL have parameter MAX_VALUE, default 2**WIDTH-1: highest legal count; range 0..MAX_VALUE; 1 <= MAX_VALUE <= 2**WIDTH-1.
REQ-003 SHALL have parameter PRESCALE, default 1: number of qualifying enable cycles per count step; PRESCALE >= 1.
REQ-004 SHALL have parameter MODE, default MODE_WRAP: boundary behaviour, MODE_WRAP or MODE_SAT.
REQ-005 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port clear, input, 1: synchronous clear to zero.
REQ-008 SHALL have port load, input, 1: synchronous parallel load.
REQ-009 SHALL have port load_value, input, WIDTH: data for load.
REQ-010 SHALL have port enable, input, 1: count qualifier.
REQ-011 SHALL have port up, input, 1: direction; 1 = increment, 0 = decrement.
REQ-012 SHALL have port q, output, WIDTH: registered count value.
REQ-013 SHALL have port tc, output, 1: terminal count, combinational.
REQ-014 SHALL have port boundary, output, 1: registered one-cycle event pulse.

Function
REQ-015 SHALL apply per-edge priority: reset > clear > load > step.
REQ-016 SHALL set q to 0 and the prescaler to 0 on clear.
REQ-017 SHALL set q to load_value on load, clamped to MAX_VALUE when load_value > MAX_VALUE, and SHALL zero the prescaler.
REQ-018 SHALL hold q when enable=0, and SHALL leave the prescaler unchanged.
REQ-019 SHALL, when enable=1 and no clear/load, increment the prescaler; on reaching PRESCALE-1 the prescaler returns to 0 and a step occurs that cycle.
REQ-020 SHALL make every enabled cycle a step when PRESCALE=1, with q updating on the same edge (latency 1 clock).
REQ-021 SHALL, on a step with up=1 and q<MAX_VALUE, set q to q+1; with up=0 and q>0, set q to q-1.
REQ-022 SHALL, on a step at the terminal value in MODE_WRAP, go MAX_VALUE->0 (up) or 0->MAX_VALUE (down).
REQ-023 SHALL, on a step at the terminal value in MODE_SAT, hold q.
REQ-024 SHALL drive tc = (up and q==MAX_VALUE) or (not up and q==0).
REQ-025 SHALL assert boundary for exactly the one cycle after any step taken while tc=1, in either mode; otherwise boundary is 0.
REQ-026 SHALL never assert boundary as a result of load or clear, even when the loaded value is terminal.
REQ-027 SHALL let a change of up take effect on the next step without resetting the prescaler.
REQ-028 SHALL compute all arithmetic in WIDTH bits; q never holds a value > MAX_VALUE.

Reset
REQ-029 SHALL, on reset assertion, immediately force q=0, boundary=0 and prescaler=0, independent of clock.
REQ-030 SHALL hold that state while reset=1 and resume normal operation on the first rising clock edge after deassertion.
REQ-031 SHALL discard any partial prescale count when reset occurs mid-operation.

Structure
REQ-032 SHALL place MODE_WRAP/MODE_SAT constants in shared package counter_pkg.
REQ-033 SHALL implement the prescaler as sub-module tick_prescaler (parameter PRESCALE; inputs clock, reset, clear, enable; output tick), with clear driven by clear or load.
REQ-034 SHALL keep all count and boundary logic in counter_mod_n.

Verification
REQ-035 SHALL verify reset: WIDTH=4, MAX_VALUE=9, reset pulsed mid-cycle at q=5 -> q=0 and boundary=0 immediately, before the next edge.
REQ-036 SHALL verify wrap: MODE_WRAP, MAX_VALUE=9, up=1, enable=1 from q=8 -> q=9 (tc=1), then 0, with boundary=1 for the one cycle after; down from 0 -> 9 with boundary pulse.
REQ-037 SHALL verify saturate: MODE_SAT, MAX_VALUE=9, up=1 at q=9 for 3 enabled cycles -> q stays 9, boundary=1 each following cycle; up=0 -> 8.
REQ-038 SHALL verify priority and clamp: load=1, load_value=15, enable=1, MAX_VALUE=9 -> q=9, boundary=0; clear=1 with load=1 -> q=0.
REQ-039 SHALL verify prescale: PRESCALE=3, enable toggled 1,1,0,1 -> q increments once, on the 4th cycle; load mid-prescale restarts the 3-cycle count.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the modulo-N counter family.
package counter_pkg;

  // Boundary behaviour when a step is taken at the terminal value.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides qualifying enable cycles down to one tick every PRESCALE enables.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // A clear on the same edge wins, so no tick leaks out of a cleared cycle.
  assign tick = enable && !clear && (cnt_q == LAST);

  // Next prescale count: restart on clear, advance on enable, hold otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  // Prescale count register; reset discards any partial count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_mod_n.sv
// Up/down modulo-N counter with prescaler, wrap or saturate at the ends,
// combinational terminal count and a registered boundary event pulse.
module counter_mod_n
  import counter_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          MAX_VALUE = 2**WIDTH - 1,
  parameter int          PRESCALE  = 1,
  parameter count_mode_e MODE      = MODE_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             boundary
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic             boundary_q, boundary_d;
  logic             tick;
  logic             step;
  logic [WIDTH-1:0] load_clamped;

  // Load also restarts the prescale window so a fresh value gets full spacing.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear | load),
    .enable (enable),
    .tick   (tick)
  );

  assign step         = tick && !clear && !load;
  assign load_clamped = (load_value > MAX_V) ? MAX_V : load_value;
  assign tc           = up ? (count_q == MAX_V) : (count_q == '0);
  assign q            = count_q;
  assign boundary     = boundary_q;

  // Next count and boundary event: clear > load > step; only steps raise boundary.
  always_comb begin
    count_d    = count_q;
    boundary_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (step) begin
      boundary_d = tc;
      if (up) begin
        if (count_q < MAX_V) begin
          count_d = count_q + WIDTH'(1);
        end else if (MODE == MODE_WRAP) begin
          count_d = '0;
        end
      end else begin
        if (count_q > '0) begin
          count_d = count_q - WIDTH'(1);
        end else if (MODE == MODE_WRAP) begin
          count_d = MAX_V;
        end
      end
    end
  end

  // Count and boundary registers with asynchronous reset to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      boundary_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      boundary_q <= boundary_d;
    end
  end

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed bench: three counter_mod_n instances (wrap, saturate, prescale-by-3),
// all WIDTH=4, MAX_VALUE=9, exercised one after another.
module tb_counter_mod_n;
  import counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: wrap mode, no prescale.
  logic       a_rst = 1'b1, a_clr = 1'b0, a_ld = 1'b0, a_en = 1'b0, a_up = 1'b1;
  logic [3:0] a_lv = 4'd0;
  logic [3:0] a_q;
  logic       a_tc, a_bd;

  // Instance B: saturate mode, no prescale.
  logic       b_rst = 1'b1, b_clr = 1'b0, b_ld = 1'b0, b_en = 1'b0, b_up = 1'b1;
  logic [3:0] b_lv = 4'd0;
  logic [3:0] b_q;
  logic       b_tc, b_bd;

  // Instance C: wrap mode, prescale by 3.
  logic       c_rst = 1'b1, c_clr = 1'b0, c_ld = 1'b0, c_en = 1'b0, c_up = 1'b1;
  logic [3:0] c_lv = 4'd0;
  logic [3:0] c_q;
  logic       c_tc, c_bd;

  counter_mod_n #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .MODE(MODE_WRAP)) u_a (
    .clock(clk), .reset(a_rst), .clear(a_clr), .load(a_ld), .load_value(a_lv),
    .enable(a_en), .up(a_up), .q(a_q), .tc(a_tc), .boundary(a_bd));

  counter_mod_n #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .MODE(MODE_SAT)) u_b (
    .clock(clk), .reset(b_rst), .clear(b_clr), .load(b_ld), .load_value(b_lv),
    .enable(b_en), .up(b_up), .q(b_q), .tc(b_tc), .boundary(b_bd));

  counter_mod_n #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(3), .MODE(MODE_WRAP)) u_c (
    .clock(clk), .reset(c_rst), .clear(c_clr), .load(c_ld), .load_value(c_lv),
    .enable(c_en), .up(c_up), .q(c_q), .tc(c_tc), .boundary(c_bd));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // ---------------- Instance A: reset, wrap, priority/clamp ----------------
    cyc();
    check_val("a_rst_q", a_q, 0);
    check_val("a_rst_bd", a_bd, 0);
    a_rst = 1'b0;
    a_ld = 1'b1; a_lv = 4'd5;
    cyc();
    a_ld = 1'b0;
    check_val("a_load5_q", a_q, 5);
    // Asynchronous reset pulse between edges.
    #2 a_rst = 1'b1;
    #1;
    check_val("a_async_rst_q", a_q, 0);
    check_val("a_async_rst_bd", a_bd, 0);
    #1 a_rst = 1'b0;
    // Wrap up: 8 -> 9 -> 0 with boundary after the terminal step.
    cyc();
    a_ld = 1'b1; a_lv = 4'd8; a_up = 1'b1;
    cyc();
    a_ld = 1'b0; a_en = 1'b1;
    check_val("a_q8", a_q, 8);
    check_val("a_tc_at8", a_tc, 0);
    cyc();
    check_val("a_q9", a_q, 9);
    check_val("a_tc_at9", a_tc, 1);
    check_val("a_bd_at9", a_bd, 0);
    cyc();
    check_val("a_wrap_q0", a_q, 0);
    check_val("a_wrap_bd", a_bd, 1);
    cyc();
    check_val("a_q1", a_q, 1);
    check_val("a_bd_drop", a_bd, 0);
    // Wrap down: 0 -> 9 with boundary.
    a_en = 1'b0; a_clr = 1'b1;
    cyc();
    a_clr = 1'b0; a_up = 1'b0;
    #1;
    check_val("a_clr_q", a_q, 0);
    check_val("a_tc_down0", a_tc, 1);
    a_en = 1'b1;
    cyc();
    check_val("a_down_wrap_q", a_q, 9);
    check_val("a_down_wrap_bd", a_bd, 1);
    cyc();
    check_val("a_down_q8", a_q, 8);
    check_val("a_down_bd0", a_bd, 0);
    // Load of a terminal value never raises boundary.
    a_en = 1'b0; a_up = 1'b1; a_ld = 1'b1; a_lv = 4'd9;
    cyc();
    a_ld = 1'b0;
    check_val("a_ld_term_q", a_q, 9);
    check_val("a_ld_term_tc", a_tc, 1);
    check_val("a_ld_term_bd", a_bd, 0);
    // Clamp with enable: load wins over step, 15 clamps to 9.
    a_ld = 1'b1; a_lv = 4'd15; a_en = 1'b1;
    cyc();
    check_val("a_clamp_q", a_q, 9);
    check_val("a_clamp_bd", a_bd, 0);
    // Clear wins over load.
    a_clr = 1'b1; a_ld = 1'b1; a_lv = 4'd7;
    cyc();
    a_clr = 1'b0; a_ld = 1'b0; a_en = 1'b0;
    check_val("a_clr_over_ld_q", a_q, 0);
    check_val("a_clr_over_ld_bd", a_bd, 0);

    // ---------------- Instance B: saturate ----------------
    b_rst = 1'b0;
    b_ld = 1'b1; b_lv = 4'd9; b_up = 1'b1;
    cyc();
    b_ld = 1'b0; b_en = 1'b1;
    check_val("b_ld9_q", b_q, 9);
    check_val("b_ld9_bd", b_bd, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_val($sformatf("b_sat%0d_q", i), b_q, 9);
      check_val($sformatf("b_sat%0d_bd", i), b_bd, 1);
    end
    b_up = 1'b0;
    cyc();
    check_val("b_down_q", b_q, 8);
    check_val("b_down_bd", b_bd, 0);
    b_en = 1'b0; b_clr = 1'b1;
    cyc();
    b_clr = 1'b0; b_en = 1'b1;
    cyc();
    check_val("b_sat0_q", b_q, 0);
    check_val("b_sat0_bd", b_bd, 1);
    b_en = 1'b0;

    // ---------------- Instance C: prescale by 3 ----------------
    c_rst = 1'b0;
    c_en = 1'b1;
    cyc();
    check_val("c_pre1_q", c_q, 0);
    cyc();
    c_en = 1'b0;
    check_val("c_pre2_q", c_q, 0);
    cyc();
    c_en = 1'b1;
    check_val("c_pre_hold_q", c_q, 0);
    cyc();
    check_val("c_pre4_q", c_q, 1);
    // Load mid-window restarts the 3-enable count.
    cyc();
    c_ld = 1'b1; c_lv = 4'd3;
    cyc();
    c_ld = 1'b0;
    check_val("c_ld_q", c_q, 3);
    cyc();
    check_val("c_ld_w1_q", c_q, 3);
    cyc();
    check_val("c_ld_w2_q", c_q, 3);
    cyc();
    check_val("c_ld_w3_q", c_q, 4);
    // Reset discards a partial prescale window.
    cyc();
    cyc();
    #2 c_rst = 1'b1;
    #1;
    check_val("c_rst_q", c_q, 0);
    #1 c_rst = 1'b0;
    cyc();
    check_val("c_rst_w1_q", c_q, 0);
    cyc();
    check_val("c_rst_w2_q", c_q, 0);
    cyc();
    check_val("c_rst_w3_q", c_q, 1);
    c_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
